// File: rtl/uart_tx_sched_pkg.sv
// Shared encodings and defaults for the UART0 transmit scheduler and its arbiter.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_POLL  = 3'd1,
    S_GAP   = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } sched_state_e;

  localparam logic [16:0] DEF_UART_BASE  = 17'h01000;
  localparam logic [16:0] DEF_THR_OFFSET = 17'h000;
  localparam logic [16:0] DEF_LSR_OFFSET = 17'h014;
  localparam int unsigned DEF_THRE_BIT   = 5;

  // side 0 is source A, side 1 is source B; grant vectors are {B,A}
  function automatic logic [1:0] side_onehot(input logic side);
    return side ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/uart_tx_rr_arb.sv
// Two-way round-robin arbiter with a message lock that pins the grant to the current owner.
module uart_tx_rr_arb
  import uart_tx_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid_i,
  input  logic       lock_i,
  input  logic       owner_i,
  input  logic       release_i,
  output logic [1:0] grant_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    grant_o = 2'b00;
    if (lock_i) begin
      if (valid_i[owner_i]) grant_o = side_onehot(owner_i);
    end else if (valid_i[ptr_q]) begin
      grant_o = side_onehot(ptr_q);
    end else if (valid_i[~ptr_q]) begin
      grant_o = side_onehot(~ptr_q);
    end
  end

  // a finished message hands priority to the other source
  assign ptr_d = release_i ? ~owner_i : ptr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 1'b0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/uart_tx_wb_scheduler.sv
// Wishbone master sharing the UART0 transmitter between two byte sources.
// state | meaning
// IDLE  | bus released; pick owner (locked owner, else round-robin)
// POLL  | read LSR; THRE set -> WRITE, clear -> GAP
// GAP   | one idle cycle before polling again
// WRITE | one setup cycle with bus released, then write byte to THR
// DONE  | ready pulse to owner; update lock and round-robin pointer
module uart_tx_wb_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int unsigned          ADDRWIDTH         = 17,
  parameter logic [ADDRWIDTH-1:0] UART_BASE_ADDRESS = DEF_UART_BASE,
  parameter logic [ADDRWIDTH-1:0] THR_OFFSET        = DEF_THR_OFFSET,
  parameter logic [ADDRWIDTH-1:0] LSR_OFFSET        = DEF_LSR_OFFSET,
  parameter int unsigned          LSR_THRE_BIT      = DEF_THRE_BIT,
  parameter int unsigned          ACK_TIMEOUT       = 15,
  parameter int unsigned          TIMEOUT_WIDTH     = 4
) (
  input  logic                 WB_CLK,
  input  logic                 WB_RSTn,
  input  logic                 reqA_valid_i,
  input  logic [7:0]           reqA_data_i,
  input  logic                 reqA_last_i,
  output logic                 reqA_ready_o,
  input  logic                 reqB_valid_i,
  input  logic [7:0]           reqB_data_i,
  input  logic                 reqB_last_i,
  output logic                 reqB_ready_o,
  output logic [ADDRWIDTH-1:0] WBm_ADR_o,
  output logic                 WBm_CYC_o,
  output logic                 WBm_STB_o,
  output logic                 WBm_WE_o,
  output logic [3:0]           WBm_BYTE_STB_o,
  output logic [31:0]          WBm_WR_DAT_o,
  input  logic [31:0]          WBm_RD_DAT_i,
  input  logic                 WBm_ACK_i,
  output logic [1:0]           grant_o,
  output logic                 busy_o,
  output logic                 timeout_err_o,
  input  logic                 clr_err_i
);

  // addresses wrap modulo 2^ADDRWIDTH by construction
  localparam logic [ADDRWIDTH-1:0] LSR_ADR  = UART_BASE_ADDRESS + LSR_OFFSET;
  localparam logic [ADDRWIDTH-1:0] THR_ADR  = UART_BASE_ADDRESS + THR_OFFSET;
  localparam logic [4:0]           THRE_IDX = 5'(LSR_THRE_BIT);

  sched_state_e           state_q, state_d;
  logic                   owner_q, owner_d;
  logic                   lock_q, lock_d;
  logic [TIMEOUT_WIDTH-1:0] tmo_q, tmo_d, tmo_inc;
  logic                   err_q, err_d;
  logic                   cyc_q, cyc_d;
  logic                   we_q, we_d;
  logic [ADDRWIDTH-1:0]   adr_q, adr_d;
  logic [3:0]             bstb_q, bstb_d;
  logic [31:0]            wdat_q, wdat_d;
  logic                   rdy_a_q, rdy_a_d;
  logic                   rdy_b_q, rdy_b_d;
  logic [1:0]             grant_q, grant_d;
  logic                   busy_q, busy_d;

  logic [1:0] arb_grant;
  logic       owner_last;
  logic [7:0] owner_data;
  logic       arb_release;
  logic       unused_rd;

  assign owner_last  = owner_q ? reqB_last_i : reqA_last_i;
  assign owner_data  = owner_q ? reqB_data_i : reqA_data_i;
  assign arb_release = (state_q == S_DONE) && owner_last;
  assign tmo_inc     = tmo_q + TIMEOUT_WIDTH'(1);
  assign unused_rd   = ^WBm_RD_DAT_i;

  uart_tx_rr_arb u_arb (
    .clk       (WB_CLK),
    .rst_n     (WB_RSTn),
    .valid_i   ({reqB_valid_i, reqA_valid_i}),
    .lock_i    (lock_q),
    .owner_i   (owner_q),
    .release_i (arb_release),
    .grant_o   (arb_grant)
  );

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    lock_d  = lock_q;
    tmo_d   = tmo_q;
    err_d   = err_q;
    cyc_d   = cyc_q;
    we_d    = we_q;
    adr_d   = adr_q;
    bstb_d  = bstb_q;
    wdat_d  = wdat_q;
    rdy_a_d = 1'b0;
    rdy_b_d = 1'b0;
    grant_d = grant_q;
    if (clr_err_i) err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (|arb_grant) begin
          owner_d = arb_grant[1];
          grant_d = arb_grant;
          state_d = S_POLL;
          cyc_d   = 1'b1;
          we_d    = 1'b0;
          adr_d   = LSR_ADR;
          bstb_d  = 4'hF;
          tmo_d   = '0;
        end
      end
      S_POLL, S_WRITE: begin
        if (!cyc_q) begin
          cyc_d = 1'b1;
        end else if (WBm_ACK_i) begin
          cyc_d = 1'b0;
          tmo_d = '0;
          if (state_q == S_POLL) begin
            if (WBm_RD_DAT_i[THRE_IDX]) begin
              state_d = S_WRITE;
              we_d    = 1'b1;
              adr_d   = THR_ADR;
              bstb_d  = 4'b0001;
              wdat_d  = {24'h0, owner_data};
            end else begin
              state_d = S_GAP;
            end
          end else begin
            state_d = S_DONE;
            rdy_a_d = ~owner_q;
            rdy_b_d = owner_q;
          end
        end else if (tmo_inc == TIMEOUT_WIDTH'(ACK_TIMEOUT)) begin
          // abort leaves lock and pointer alone so the same byte is retried
          cyc_d   = 1'b0;
          err_d   = 1'b1;
          tmo_d   = '0;
          grant_d = 2'b00;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_inc;
        end
      end
      S_GAP: begin
        state_d = S_POLL;
        cyc_d   = 1'b1;
        we_d    = 1'b0;
        adr_d   = LSR_ADR;
        bstb_d  = 4'hF;
        tmo_d   = '0;
      end
      S_DONE: begin
        lock_d  = ~owner_last;
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
      default: begin
        cyc_d   = 1'b0;
        grant_d = 2'b00;
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge WB_CLK or negedge WB_RSTn) begin
    if (!WB_RSTn) begin
      state_q <= S_IDLE;
      owner_q <= 1'b0;
      lock_q  <= 1'b0;
      tmo_q   <= '0;
      err_q   <= 1'b0;
      cyc_q   <= 1'b0;
      we_q    <= 1'b0;
      adr_q   <= '0;
      bstb_q  <= 4'h0;
      wdat_q  <= 32'h0;
      rdy_a_q <= 1'b0;
      rdy_b_q <= 1'b0;
      grant_q <= 2'b00;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      lock_q  <= lock_d;
      tmo_q   <= tmo_d;
      err_q   <= err_d;
      cyc_q   <= cyc_d;
      we_q    <= we_d;
      adr_q   <= adr_d;
      bstb_q  <= bstb_d;
      wdat_q  <= wdat_d;
      rdy_a_q <= rdy_a_d;
      rdy_b_q <= rdy_b_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

  assign WBm_CYC_o      = cyc_q;
  assign WBm_STB_o      = cyc_q;
  assign WBm_WE_o       = we_q;
  assign WBm_ADR_o      = adr_q;
  assign WBm_BYTE_STB_o = bstb_q;
  assign WBm_WR_DAT_o   = wdat_q;
  assign reqA_ready_o   = rdy_a_q;
  assign reqB_ready_o   = rdy_b_q;
  assign grant_o        = grant_q;
  assign busy_o         = busy_q;
  assign timeout_err_o  = err_q;

endmodule

// File: tb/tb_uart_tx_wb_scheduler.sv
// Directed bench for the UART0 transmit scheduler with a small LSR/THR slave model.
module tb_uart_tx_wb_scheduler;

  typedef struct packed {
    logic [16:0] adr;
    logic        we;
    logic [31:0] dat;
    logic [3:0]  bs;
    logic [1:0]  gnt;
    logic [31:0] cyc;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reqA_valid, reqA_last, readyA;
  logic [7:0]  reqA_data;
  logic        reqB_valid, reqB_last, readyB;
  logic [7:0]  reqB_data;
  logic [16:0] adr;
  logic        cyc, stb, we;
  logic [3:0]  bs;
  logic [31:0] wdat;
  logic [31:0] rdat = 32'h0;
  logic        ack = 1'b0;
  logic [1:0]  grant;
  logic        busy, err;
  logic        clr_err;

  int          total, bad;
  logic [31:0] cyc_cnt = 32'd0;
  bit          ack_en;
  int          lsr_zero;
  rec_t        wb_log[$];
  logic [31:0] rdyA_log[$];
  logic [31:0] rdyB_log[$];

  uart_tx_wb_scheduler dut (
    .WB_CLK         (clk),
    .WB_RSTn        (rst_n),
    .reqA_valid_i   (reqA_valid),
    .reqA_data_i    (reqA_data),
    .reqA_last_i    (reqA_last),
    .reqA_ready_o   (readyA),
    .reqB_valid_i   (reqB_valid),
    .reqB_data_i    (reqB_data),
    .reqB_last_i    (reqB_last),
    .reqB_ready_o   (readyB),
    .WBm_ADR_o      (adr),
    .WBm_CYC_o      (cyc),
    .WBm_STB_o      (stb),
    .WBm_WE_o       (we),
    .WBm_BYTE_STB_o (bs),
    .WBm_WR_DAT_o   (wdat),
    .WBm_RD_DAT_i   (rdat),
    .WBm_ACK_i      (ack),
    .grant_o        (grant),
    .busy_o         (busy),
    .timeout_err_o  (err),
    .clr_err_i      (clr_err)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 32'd1;

  // zero-wait slave: ACK asserted in the same cycle the strobe is seen
  always @(negedge clk) begin
    rec_t r;
    ack  = 1'b0;
    rdat = 32'h0;
    if (cyc && stb && ack_en) begin
      ack = 1'b1;
      if (!we) begin
        if (lsr_zero > 0) begin rdat = 32'h0000_0000; lsr_zero--; end
        else rdat = 32'h0000_0020;
      end
      r.adr = adr; r.we = we; r.dat = wdat; r.bs = bs; r.gnt = grant; r.cyc = cyc_cnt;
      wb_log.push_back(r);
    end
    if (readyA) rdyA_log.push_back(cyc_cnt);
    if (readyB) rdyB_log.push_back(cyc_cnt);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at 200000, required finish earlier");
    $fatal(1);
  end

  task automatic clear_logs();
    wb_log.delete();
    rdyA_log.delete();
    rdyB_log.delete();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic src_byte(input logic side, input logic [7:0] d, input logic last, input logic keep_valid);
    int  n;
    bit  seen;
    n = 0;
    seen = 0;
    if (side) begin reqB_valid = 1'b1; reqB_data = d; reqB_last = last; end
    else      begin reqA_valid = 1'b1; reqA_data = d; reqA_last = last; end
    while (!seen && n < 300) begin
      @(negedge clk);
      n++;
      seen = ((side ? readyB : readyA) === 1'b1);
    end
    total++;
    if (!seen) begin
      bad++;
      $display("FAIL src_ready side=%0d data=%h: got no ready pulse in 300 cycles, required one", side, d);
    end
    @(posedge clk);
    #1;
    if (!keep_valid) begin
      if (side) reqB_valid = 1'b0;
      else      reqA_valid = 1'b0;
    end
  endtask

  task automatic test_reset();
    #3;
    total++;
    if ({cyc, stb, we, adr, bs, wdat} !== 55'h0) begin
      bad++;
      $display("FAIL reset_bus: cyc=%b stb=%b we=%b adr=%h bs=%h dat=%h, required all 0", cyc, stb, we, adr, bs, wdat);
    end
    total++;
    if ({readyA, readyB, grant, busy, err} !== 6'h0) begin
      bad++;
      $display("FAIL reset_status: rdyA=%b rdyB=%b grant=%b busy=%b err=%b, required all 0", readyA, readyB, grant, busy, err);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({cyc, busy, grant} !== 4'h0) begin
      bad++;
      $display("FAIL reset_idle: cyc=%b busy=%b grant=%b with no requests, required 0", cyc, busy, grant);
    end
  endtask

  task automatic test_single_msg();
    logic [7:0]  msg [3];
    logic [21:0] exp_hdr, got_hdr;
    msg[0] = 8'h41; msg[1] = 8'h42; msg[2] = 8'h43;
    clear_logs();
    src_byte(1'b0, msg[0], 1'b0, 1'b1);
    src_byte(1'b0, msg[1], 1'b0, 1'b1);
    src_byte(1'b0, msg[2], 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    total++;
    if (wb_log.size() != 6) begin
      bad++;
      $display("FAIL msg_bus_count: got %0d bus cycles, required 6", wb_log.size());
    end
    for (int i = 0; i < 6 && i < wb_log.size(); i++) begin
      exp_hdr = (i % 2 == 0) ? {17'h01014, 1'b0, 4'hF} : {17'h01000, 1'b1, 4'b0001};
      got_hdr = {wb_log[i].adr, wb_log[i].we, wb_log[i].bs};
      total++;
      if (got_hdr !== exp_hdr) begin
        bad++;
        $display("FAIL msg_hdr[%0d]: got adr/we/bs %h, required %h", i, got_hdr, exp_hdr);
      end
      if (i % 2 == 1) begin
        total++;
        if ({wb_log[i].gnt, wb_log[i].dat} !== {2'b01, 24'h0, msg[i/2]}) begin
          bad++;
          $display("FAIL msg_thr[%0d]: got grant=%b dat=%h, required grant=01 dat=%h", i, wb_log[i].gnt, wb_log[i].dat, {24'h0, msg[i/2]});
        end
      end
    end
    total++;
    if (rdyA_log.size() != 3 || rdyB_log.size() != 0) begin
      bad++;
      $display("FAIL msg_ready_count: got A=%0d B=%0d pulses, required A=3 B=0", rdyA_log.size(), rdyB_log.size());
    end else begin
      for (int i = 1; i < 3; i++) begin
        total++;
        if (rdyA_log[i] - rdyA_log[i-1] != 32'd5) begin
          bad++;
          $display("FAIL msg_spacing[%0d]: got %0d cycles between ready pulses, required 5", i, rdyA_log[i] - rdyA_log[i-1]);
        end
      end
      if (wb_log.size() == 6) begin
        total++;
        if (rdyA_log[2] != wb_log[5].cyc + 32'd1) begin
          bad++;
          $display("FAIL msg_latency: ready in cycle %0d, required %0d (THR ack + 1)", rdyA_log[2], wb_log[5].cyc + 32'd1);
        end
      end
    end
    total++;
    if ({busy, grant, cyc} !== 4'h0) begin
      bad++;
      $display("FAIL msg_idle_after: busy=%b grant=%b cyc=%b, required 0", busy, grant, cyc);
    end
  endtask

  task automatic test_rr_no_interleave();
    rec_t       wr[$];
    logic [7:0] exp_dat [4];
    logic [1:0] exp_gnt [4];
    exp_dat[0] = 8'h11; exp_dat[1] = 8'h12; exp_dat[2] = 8'h21; exp_dat[3] = 8'h22;
    exp_gnt[0] = 2'b01; exp_gnt[1] = 2'b01; exp_gnt[2] = 2'b10; exp_gnt[3] = 2'b10;
    apply_reset();
    clear_logs();
    fork
      begin src_byte(1'b0, 8'h11, 1'b0, 1'b1); src_byte(1'b0, 8'h12, 1'b1, 1'b0); end
      begin src_byte(1'b1, 8'h21, 1'b0, 1'b1); src_byte(1'b1, 8'h22, 1'b1, 1'b0); end
    join
    repeat (2) @(negedge clk);
    foreach (wb_log[i]) if (wb_log[i].we) wr.push_back(wb_log[i]);
    total++;
    if (wr.size() != 4) begin
      bad++;
      $display("FAIL rr_write_count: got %0d THR writes, required 4", wr.size());
    end
    for (int i = 0; i < 4 && i < wr.size(); i++) begin
      total++;
      if ({wr[i].gnt, wr[i].dat} !== {exp_gnt[i], 24'h0, exp_dat[i]}) begin
        bad++;
        $display("FAIL rr_order[%0d]: got grant=%b dat=%h, required grant=%b dat=%h", i, wr[i].gnt, wr[i].dat, exp_gnt[i], {24'h0, exp_dat[i]});
      end
    end
  endtask

  task automatic test_thre_poll();
    clear_logs();
    lsr_zero = 2;
    src_byte(1'b0, 8'h55, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    total++;
    if (wb_log.size() != 4) begin
      bad++;
      $display("FAIL poll_count: got %0d bus cycles, required 4 (3 LSR reads + 1 THR write)", wb_log.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        total++;
        if ({wb_log[i].adr, wb_log[i].we} !== {17'h01014, 1'b0}) begin
          bad++;
          $display("FAIL poll_read[%0d]: got adr=%h we=%b, required adr=01014 we=0", i, wb_log[i].adr, wb_log[i].we);
        end
      end
      for (int i = 1; i < 3; i++) begin
        total++;
        if (wb_log[i].cyc - wb_log[i-1].cyc != 32'd2) begin
          bad++;
          $display("FAIL poll_gap[%0d]: got %0d cycles between LSR reads, required 2", i, wb_log[i].cyc - wb_log[i-1].cyc);
        end
      end
      total++;
      if ({wb_log[3].adr, wb_log[3].we, wb_log[3].dat} !== {17'h01000, 1'b1, 32'h0000_0055}) begin
        bad++;
        $display("FAIL poll_write: got adr=%h we=%b dat=%h, required adr=01000 we=1 dat=00000055", wb_log[3].adr, wb_log[3].we, wb_log[3].dat);
      end
    end
    total++;
    if (rdyA_log.size() != 1) begin
      bad++;
      $display("FAIL poll_ready: got %0d ready pulses, required 1", rdyA_log.size());
    end
  endtask

  task automatic test_timeout();
    int hi, w;
    clear_logs();
    ack_en = 0;
    fork
      src_byte(1'b0, 8'h66, 1'b1, 1'b0);
      begin
        w = 0; hi = 0;
        while (cyc !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        while (cyc === 1'b1 && hi < 40) begin hi++; @(negedge clk); end
        total++;
        if (hi != 15) begin
          bad++;
          $display("FAIL tmo_strobe_len: got %0d STB cycles without ACK, required 15", hi);
        end
        total++;
        if ({err, busy, grant, stb} !== 5'b1_0_00_0) begin
          bad++;
          $display("FAIL tmo_abort: got err=%b busy=%b grant=%b stb=%b, required err=1 busy=0 grant=00 stb=0", err, busy, grant, stb);
        end
        ack_en = 1;
      end
    join
    repeat (2) @(negedge clk);
    total++;
    if (wb_log.size() != 2 || wb_log[wb_log.size()-1].dat !== 32'h0000_0066) begin
      bad++;
      $display("FAIL tmo_retry: got %0d bus cycles, required 2 ending in THR write of 00000066", wb_log.size());
    end
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL tmo_sticky: got err=%b after retry, required 1", err);
    end
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL tmo_clear: got err=%b after clr_err_i, required 0", err);
    end
    clr_err = 1'b1;
    ack_en = 0;
    fork
      src_byte(1'b0, 8'h67, 1'b1, 1'b0);
      begin
        w = 0; hi = 0;
        while (cyc !== 1'b1 && w < 20) begin @(negedge clk); w++; end
        while (cyc === 1'b1 && hi < 40) begin hi++; @(negedge clk); end
        total++;
        if (err !== 1'b1) begin
          bad++;
          $display("FAIL tmo_set_wins: got err=%b with clr and timeout together, required 1", err);
        end
        clr_err = 1'b0;
        ack_en = 1;
        @(negedge clk);
        total++;
        if (err !== 1'b1) begin
          bad++;
          $display("FAIL tmo_set_hold: got err=%b one cycle later, required 1", err);
        end
      end
    join
    clr_err = 1'b1;
    @(negedge clk);
    clr_err = 1'b0;
  endtask

  task automatic test_reset_mid_write();
    int w;
    fork
      src_byte(1'b0, 8'h77, 1'b1, 1'b0);
      begin
        w = 0;
        while (!(cyc === 1'b1 && we === 1'b1) && w < 40) begin @(negedge clk); w++; end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if ({cyc, stb, readyA, grant, busy} !== 6'h0) begin
          bad++;
          $display("FAIL rst_async: got cyc=%b stb=%b rdyA=%b grant=%b busy=%b during reset, required 0", cyc, stb, readyA, grant, busy);
        end
        repeat (2) @(negedge clk);
        clear_logs();
        rst_n = 1'b1;
      end
    join
    repeat (2) @(negedge clk);
    total++;
    if (wb_log.size() != 2) begin
      bad++;
      $display("FAIL rst_restart_count: got %0d bus cycles after reset, required 2", wb_log.size());
    end else begin
      total++;
      if ({wb_log[0].adr, wb_log[0].we, wb_log[0].gnt} !== {17'h01014, 1'b0, 2'b01}) begin
        bad++;
        $display("FAIL rst_restart_poll: got adr=%h we=%b grant=%b, required adr=01014 we=0 grant=01", wb_log[0].adr, wb_log[0].we, wb_log[0].gnt);
      end
      total++;
      if ({wb_log[1].we, wb_log[1].dat} !== {1'b1, 32'h0000_0077}) begin
        bad++;
        $display("FAIL rst_restart_write: got we=%b dat=%h, required we=1 dat=00000077", wb_log[1].we, wb_log[1].dat);
      end
    end
    total++;
    if (rdyA_log.size() != 1) begin
      bad++;
      $display("FAIL rst_restart_ready: got %0d ready pulses after reset, required 1", rdyA_log.size());
    end
  endtask

  task automatic test_lock_hold();
    rec_t       wr[$];
    logic [7:0] exp_dat [3];
    logic [1:0] exp_gnt [3];
    exp_dat[0] = 8'hB1; exp_dat[1] = 8'hB2; exp_dat[2] = 8'hA1;
    exp_gnt[0] = 2'b10; exp_gnt[1] = 2'b10; exp_gnt[2] = 2'b01;
    clear_logs();
    src_byte(1'b1, 8'hB1, 1'b0, 1'b0);
    fork
      src_byte(1'b0, 8'hA1, 1'b1, 1'b0);
      begin : hold_b
        int viol;
        viol = 0;
        for (int i = 0; i < 20; i++) begin
          @(negedge clk);
          if (grant !== 2'b00 || busy !== 1'b0 || readyA !== 1'b0) viol++;
        end
        total++;
        if (viol != 0) begin
          bad++;
          $display("FAIL lock_block: got %0d cycles with grant/busy/readyA active while B locked, required 0", viol);
        end
        src_byte(1'b1, 8'hB2, 1'b1, 1'b0);
      end
    join
    repeat (2) @(negedge clk);
    foreach (wb_log[i]) if (wb_log[i].we) wr.push_back(wb_log[i]);
    total++;
    if (wr.size() != 3) begin
      bad++;
      $display("FAIL lock_write_count: got %0d THR writes, required 3", wr.size());
    end
    for (int i = 0; i < 3 && i < wr.size(); i++) begin
      total++;
      if ({wr[i].gnt, wr[i].dat} !== {exp_gnt[i], 24'h0, exp_dat[i]}) begin
        bad++;
        $display("FAIL lock_order[%0d]: got grant=%b dat=%h, required grant=%b dat=%h", i, wr[i].gnt, wr[i].dat, exp_gnt[i], {24'h0, exp_dat[i]});
      end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst_n = 1'b0;
    reqA_valid = 1'b0; reqA_data = 8'h0; reqA_last = 1'b0;
    reqB_valid = 1'b0; reqB_data = 8'h0; reqB_last = 1'b0;
    clr_err = 1'b0;
    ack_en = 1;
    lsr_zero = 0;
    test_reset();
    test_single_msg();
    test_rr_no_interleave();
    test_thre_poll();
    test_timeout();
    test_reset_mid_write();
    test_lock_hold();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
